// File: rtl/debug_display_bank_pkg.sv
// debug_display_bank_pkg: shared constants, types and helpers for the debug display bank
package debug_display_bank_pkg;

   localparam logic [6:0] SEG_BLANK = 7'b0;

   typedef enum logic [1:0] {LD_NONE, LD_REFRESH, LD_PAGE, LD_FREEZE} load_src_t;

   function automatic int clog2_min1(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

   function automatic int ch_base(input int ch, input int w);
      return ch * w;
   endfunction

endpackage

// File: rtl/debug_display_bank_btn_debounce.sv
// btn_debounce: synchronise a raw button, accept a level after DEB_CYCLES stable samples, pulse on press
module btn_debounce
   import debug_display_bank_pkg::*;
#(
   parameter int DEB_CYCLES = 50000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn,
   output logic rise
);

   localparam int DW = clog2_min1(DEB_CYCLES);

   logic          s0, s1, lvl, done;
   logic [DW-1:0] cnt;

   assign done = (s1 != lvl) && (cnt == DW'(DEB_CYCLES - 1));

   // two-flop synchroniser, stable-sample counter and one-cycle press pulse
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s0   <= 1'b0;
         s1   <= 1'b0;
         lvl  <= 1'b0;
         cnt  <= '0;
         rise <= 1'b0;
      end else begin
         s0   <= btn;
         s1   <= s0;
         cnt  <= (s1 == lvl || done) ? '0 : cnt + 1'b1;
         lvl  <= done ? s1 : lvl;
         rise <= done & s1;
      end
   end

endmodule

// File: rtl/dig_ctrl.sv
// dig_ctrl: hex nibble to active-high 7-segment code, bit order {g,f,e,d,c,b,a}
module dig_ctrl (
   input  logic [3:0] digit,
   output logic [6:0] seg
);

   // full 0-F table; F lives in the default arm
   always_comb begin
      case (digit)
         4'h0: seg = 7'h3F;
         4'h1: seg = 7'h06;
         4'h2: seg = 7'h5B;
         4'h3: seg = 7'h4F;
         4'h4: seg = 7'h66;
         4'h5: seg = 7'h6D;
         4'h6: seg = 7'h7D;
         4'h7: seg = 7'h07;
         4'h8: seg = 7'h7F;
         4'h9: seg = 7'h6F;
         4'hA: seg = 7'h77;
         4'hB: seg = 7'h7C;
         4'hC: seg = 7'h39;
         4'hD: seg = 7'h5E;
         4'hE: seg = 7'h79;
         default: seg = 7'h71;
      endcase
   end

endmodule

// File: rtl/debug_display_bank.sv
// debug_display_bank: pages NUM_CH debug words onto NUM_DIG 7-segment digits with refresh, freeze and blanking
module debug_display_bank
   import debug_display_bank_pkg::*;
#(
   parameter int NUM_DIG     = 8,
   parameter int NUM_CH      = 4,
   parameter int REFRESH_DIV = 1000000,
   parameter int DEB_CYCLES  = 50000
) (
   input  logic                                clk,
   input  logic                                rst_n,
   input  logic [NUM_CH*4*NUM_DIG-1:0]         ch_data,
   input  logic                                page_btn,
   input  logic                                freeze,
   input  logic                                lz_blank,
   output logic [7*NUM_DIG-1:0]                led,
   output logic [clog2_min1(NUM_CH)-1:0]       ch_sel,
   output logic                                frozen
);

   localparam int W  = 4 * NUM_DIG;
   localparam int CW = clog2_min1(NUM_CH);
   localparam int RW = clog2_min1(REFRESH_DIV);

   logic                 page_rise, wrap;
   logic [CW-1:0]        ch_nxt;
   logic [RW-1:0]        ref_cnt;
   logic [W-1:0]         disp;
   logic [W-1:0]         ch_arr [NUM_CH];
   logic [7*NUM_DIG-1:0] seg, led_nxt;
   logic [NUM_DIG-1:0]   nz;
   load_src_t            src;

   btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_page (
      .clk  (clk),
      .rst_n(rst_n),
      .btn  (page_btn),
      .rise (page_rise)
   );

   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      assign ch_arr[c] = ch_data[ch_base(c, W) +: W];
   end

   for (genvar d = 0; d < NUM_DIG; d++) begin : g_dig
      dig_ctrl u_dig (
         .digit(disp[4*d +: 4]),
         .seg  (seg[7*d +: 7])
      );
      assign nz[d] = |disp[W-1:4*d];
      assign led_nxt[7*d +: 7] = (lz_blank && d != 0 && !nz[d]) ? SEG_BLANK : seg[7*d +: 7];
   end

   assign wrap = ref_cnt == RW'(REFRESH_DIV - 1);

   // a load always takes the post-page channel, so a page press on a wrap is a single load
   always_comb begin
      ch_nxt = page_rise ? ((ch_sel == CW'(NUM_CH - 1)) ? '0 : ch_sel + CW'(1)) : ch_sel;
      src    = frozen ? LD_NONE : page_rise ? LD_PAGE : freeze ? LD_FREEZE : wrap ? LD_REFRESH : LD_NONE;
   end

   // channel select, freeze state, refresh divider, display register and registered segment bus
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ch_sel  <= '0;
         frozen  <= 1'b0;
         ref_cnt <= '0;
         disp    <= '0;
         led     <= '0;
      end else begin
         ch_sel  <= ch_nxt;
         frozen  <= freeze;
         ref_cnt <= wrap ? '0 : ref_cnt + 1'b1;
         disp    <= (src != LD_NONE) ? ch_arr[ch_nxt] : disp;
         led     <= led_nxt;
      end
   end

endmodule

// File: tb/tb_debug_display_bank.sv
// tb_debug_display_bank: directed vector table plus paging, freeze and reset sequences
module tb_debug_display_bank;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [127:0] ch_data;
   logic         page_btn, freeze, lz_blank;
   logic [55:0]  led;
   logic [1:0]   ch_sel;
   logic         frozen;

   int nvec = 0;
   int nerr = 0;
   int rc   = 0;
   logic cnt_en = 1'b0;

   logic [6:0] seg_tab [0:15] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                  7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

   typedef struct {
      logic [31:0] val;
      logic        lz;
      logic [55:0] exp;
   } vec_t;

   vec_t vt [9];

   debug_display_bank #(.NUM_DIG(8), .NUM_CH(4), .REFRESH_DIV(16), .DEB_CYCLES(4)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .ch_data (ch_data),
      .page_btn(page_btn),
      .freeze  (freeze),
      .lz_blank(lz_blank),
      .led     (led),
      .ch_sel  (ch_sel),
      .frozen  (frozen)
   );

   always #5 clk = ~clk;

   function automatic logic [55:0] enc8(input logic [31:0] v);
      logic [55:0] r;
      for (int d = 0; d < 8; d++) r[d*7 +: 7] = seg_tab[v[d*4 +: 4]];
      return r;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      rc = (rc == 15) ? 0 : rc + 1;
      if (cnt_en) for (int c = 0; c < 4; c++) ch_data[c*32 +: 32] = ch_data[c*32 +: 32] + 32'd1;
   endtask

   task automatic wait_rc(input int target, input string nm);
      int n = 0;
      do begin
         tick();
         n++;
      end while (rc != target && n < 40);
      if (rc != target) chk({nm, "_timeout"}, 64'(rc), 64'(target));
   endtask

   task automatic press(input int hold);
      page_btn = 1'b1;
      repeat (hold) tick();
      page_btn = 1'b0;
      repeat (10) tick();
   endtask

   initial begin
      logic [31:0] v;
      logic        ok;
      vt[0] = '{32'h1234ABCD, 1'b0, {7'h06, 7'h5B, 7'h4F, 7'h66, 7'h77, 7'h7C, 7'h39, 7'h5E}};
      vt[1] = '{32'h000000A0, 1'b1, {{6{7'h00}}, 7'h77, 7'h3F}};
      vt[2] = '{32'h00000000, 1'b1, {{7{7'h00}}, 7'h3F}};
      vt[3] = '{32'h00000000, 1'b0, {8{7'h3F}}};
      vt[4] = '{32'hDEADBEEF, 1'b0, {7'h5E, 7'h79, 7'h77, 7'h5E, 7'h7C, 7'h79, 7'h79, 7'h71}};
      vt[5] = '{32'h00000001, 1'b1, {{7{7'h00}}, 7'h06}};
      vt[6] = '{32'h80000000, 1'b1, {7'h7F, {7{7'h3F}}}};
      vt[7] = '{32'h0F005678, 1'b1, {7'h00, 7'h71, 7'h3F, 7'h3F, 7'h6D, 7'h7D, 7'h07, 7'h7F}};
      vt[8] = '{32'h99990000, 1'b0, {{4{7'h6F}}, {4{7'h3F}}}};

      rst_n = 1'b0;
      for (int i = 0; i < 5; i++) begin
         ch_data  = {$urandom, $urandom, $urandom, $urandom};
         page_btn = 1'($urandom_range(0, 1));
         freeze   = 1'($urandom_range(0, 1));
         lz_blank = 1'($urandom_range(0, 1));
         @(posedge clk);
         #1;
      end
      chk("reset_led", 64'(led), 64'd0);
      chk("reset_ch_sel", 64'(ch_sel), 64'd0);
      chk("reset_frozen", 64'(frozen), 64'd0);

      ch_data  = '0;
      ch_data[31:0] = 32'h1234ABCD;
      page_btn = 1'b0;
      freeze   = 1'b0;
      lz_blank = 1'b0;
      rst_n    = 1'b1;
      rc       = 0;
      repeat (16) tick();
      chk("before_first_wrap", 64'(led), 64'({8{7'h3F}}));
      tick();
      chk("first_wrap", 64'(led), 64'(vt[0].exp));

      for (int i = 0; i < 9; i++) begin
         ch_data[31:0] = vt[i].val;
         lz_blank = vt[i].lz;
         wait_rc(0, "vec_wrap");
         tick();
         chk($sformatf("vec%0d", i), 64'(led), 64'(vt[i].exp));
      end

      ch_data[31:0] = 32'h000000A0;
      lz_blank = 1'b1;
      wait_rc(0, "lz_wrap");
      tick();
      chk("lz_on", 64'(led), 64'(vt[1].exp));
      lz_blank = 1'b0;
      tick();
      chk("lz_off_1cyc", 64'(led), 64'({{6{7'h3F}}, 7'h77, 7'h3F}));
      lz_blank = 1'b1;
      tick();
      chk("lz_on_again", 64'(led), 64'(vt[1].exp));

      ch_data[31:0] = 32'h0;
      lz_blank = 1'b0;
      press(3);
      chk("short_pulse", 64'(ch_sel), 64'd0);
      for (int k = 1; k <= 4; k++) begin
         press(6);
         chk($sformatf("page%0d", k), 64'(ch_sel), 64'(k % 4));
      end

      ch_data[63:32] = 32'hDEADBEEF;
      wait_rc(2, "page_sync");
      page_btn = 1'b1;
      repeat (6) tick();
      chk("page_pre_sel", 64'(ch_sel), 64'd0);
      tick();
      chk("page_sel", 64'(ch_sel), 64'd1);
      chk("page_led_old", 64'(led), 64'({8{7'h3F}}));
      tick();
      chk("page_led_new", 64'(led), 64'(vt[4].exp));
      page_btn = 1'b0;
      repeat (10) tick();

      ch_data[95:64] = 32'h22222222;
      wait_rc(9, "coin_sync");
      page_btn = 1'b1;
      repeat (6) tick();
      chk("coin_led_old", 64'(led), 64'(vt[4].exp));
      tick();
      chk("coin_wrap", 64'(rc), 64'd0);
      chk("coin_sel", 64'(ch_sel), 64'd2);
      tick();
      chk("coin_led_new", 64'(led), 64'({8{7'h5B}}));
      page_btn = 1'b0;
      repeat (10) tick();

      ch_data[95:64]  = 32'h20000000;
      ch_data[127:96] = 32'h30000000;
      cnt_en = 1'b1;
      repeat (5) tick();
      freeze = 1'b1;
      v = ch_data[95:64];
      tick();
      chk("frozen_set", 64'(frozen), 64'd1);
      tick();
      chk("freeze_snap", 64'(led), 64'(enc8(v)));
      ok = 1'b1;
      repeat (48) begin
         tick();
         if (led !== enc8(v)) ok = 1'b0;
      end
      chk("freeze_hold", 64'(ok), 64'd1);
      press(8);
      chk("frozen_page_sel", 64'(ch_sel), 64'd3);
      chk("frozen_page_led", 64'(led), 64'(enc8(v)));
      freeze = 1'b0;
      tick();
      chk("frozen_clr", 64'(frozen), 64'd0);
      chk("unfreeze_hold", 64'(led), 64'(enc8(v)));
      wait_rc(0, "unfreeze_wrap");
      v = ch_data[127:96] - 32'd1;
      tick();
      chk("unfreeze_live", 64'(led), 64'(enc8(v)));
      cnt_en = 1'b0;

      freeze = 1'b1;
      repeat (3) tick();
      page_btn = 1'b1;
      repeat (2) tick();
      #3;
      rst_n = 1'b0;
      #1;
      chk("async_led", 64'(led), 64'd0);
      chk("async_ch_sel", 64'(ch_sel), 64'd0);
      chk("async_frozen", 64'(frozen), 64'd0);
      freeze = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      rc = 0;
      repeat (6) tick();
      chk("deb_restart_pre", 64'(ch_sel), 64'd0);
      tick();
      chk("deb_restart", 64'(ch_sel), 64'd1);
      page_btn = 1'b0;
      repeat (4) tick();

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
